mem_access_unit: RTL and testbench

- MEM-stage data-memory controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues word, halfword and byte loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Delivers an aligned, extended load result as MEM_ReadData for the MEM/WB register.

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: size codes,
// FSM states, byte-enable constants and the alignment / store-lane helpers.
package mem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   // Size code 2'b11 falls into the word branches everywhere.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_HALF: return addr_lo[0];
         SZ_BYTE: return 1'b0;
         default: return (addr_lo != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_HALF: return addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
         SZ_BYTE: return BE_BYTE0 << addr_lo;
         default: return BE_WORD;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         SZ_HALF: return {2{wd[15:0]}};
         SZ_BYTE: return {4{wd[7:0]}};
         default: return wd;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane select with sign/zero extension; shared with the
// writeback forwarding path.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   output logic [31:0] data
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
   end

   always_comb begin
      data = rdata;
      case (size)
         SZ_HALF: data = load_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
         SZ_BYTE: data = load_unsigned ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: req/ack handshake, pipeline stall, load
// alignment. Define MEM_TIMEOUT_EN to abort unanswered requests with BusErr.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              Clk,
   input  logic              Clr,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic [1:0]        MEM_MemSize,
   input  logic              MEM_LoadUnsigned,
   input  logic [31:0]       MEM_ALUResult,
   input  logic [31:0]       MEM_WriteData,
   output logic              DM_Req,
   output logic              DM_We,
   output logic [ADDR_W-1:0] DM_Addr,
   output logic [31:0]       DM_WData,
   output logic [3:0]        DM_BE,
   input  logic              DM_Ack,
   input  logic [31:0]       DM_RData,
   output logic [31:0]       MEM_ReadData,
   output logic              MemStall,
   output logic              MisalignExc,
   output logic              BusErr
);

   state_t              state;
   logic                req_reg;
   logic                we_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [31:0]         wdata_reg;
   logic [3:0]          be_reg;
   logic [1:0]          size_reg;
   logic [1:0]          addr_lo_reg;
   logic                unsigned_reg;
   logic [31:0]         read_data_reg;
   logic                bus_err_reg;
   logic [31:0]         load_word;
   logic                access;
   logic                bad_align;
   logic                timeout;
   logic                unused_bits;

   assign access    = MEM_MemRead | MEM_MemWrite;
   assign bad_align = misaligned(MEM_MemSize, MEM_ALUResult[1:0]);

   assign unused_bits = ^MEM_ALUResult[31:ADDR_W+2];

   mem_load_align u_align (
      .rdata         (DM_RData),
      .addr_lo       (addr_lo_reg),
      .size          (size_reg),
      .load_unsigned (unsigned_reg),
      .data          (load_word)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wait_cnt_reg;

   // Stays zero outside WAIT, so each new access starts counting from 0.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr)
         wait_cnt_reg <= '0;
      else if (state != ST_WAIT)
         wait_cnt_reg <= '0;
      else if (!DM_Ack)
         wait_cnt_reg <= wait_cnt_reg + 1'b1;
   end

   assign timeout = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state         <= ST_IDLE;
         req_reg       <= 1'b0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         be_reg        <= BE_NONE;
         size_reg      <= SZ_WORD;
         addr_lo_reg   <= 2'b00;
         unsigned_reg  <= 1'b0;
         read_data_reg <= '0;
         bus_err_reg   <= 1'b0;
      end else begin
         bus_err_reg <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (access && !bad_align) begin
                  req_reg      <= 1'b1;
                  we_reg       <= MEM_MemWrite;
                  addr_reg     <= MEM_ALUResult[ADDR_W+1:2];
                  wdata_reg    <= store_data(MEM_MemSize, MEM_WriteData);
                  be_reg       <= store_be(MEM_MemSize, MEM_ALUResult[1:0]);
                  size_reg     <= MEM_MemSize;
                  addr_lo_reg  <= MEM_ALUResult[1:0];
                  unsigned_reg <= MEM_LoadUnsigned;
                  state        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (DM_Ack || timeout) begin
                  read_data_reg <= (DM_Ack && !we_reg) ? load_word : 32'h0;
                  bus_err_reg   <= !DM_Ack;
                  req_reg       <= 1'b0;
                  we_reg        <= 1'b0;
                  be_reg        <= BE_NONE;
                  addr_reg      <= '0;
                  wdata_reg     <= '0;
                  state         <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign DM_Req       = req_reg;
   assign DM_We        = we_reg;
   assign DM_Addr      = addr_reg;
   assign DM_WData     = wdata_reg;
   assign DM_BE        = be_reg;
   assign BusErr       = bus_err_reg;
   // Result is only presented in DONE; every other cycle the stage sees zero.
   assign MEM_ReadData = (state == ST_DONE) ? read_data_reg : 32'h0;
   assign MemStall     = !Clr && ((state == ST_WAIT) ||
                                  ((state == ST_IDLE) && access && !bad_align));
   assign MisalignExc  = !Clr && (state == ST_IDLE) && access && bad_align;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; the timeout case is exercised only
// when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

   localparam int ADDR_W = 12;
`ifdef MEM_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 64;
`endif

   logic              clk;
   logic              clr;
   logic              mem_read;
   logic              mem_write;
   logic [1:0]        mem_size;
   logic              load_unsigned;
   logic [31:0]       alu_result;
   logic [31:0]       write_data;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [3:0]        dm_be;
   logic              dm_ack;
   logic [31:0]       dm_rdata;
   logic [31:0]       read_data;
   logic              mem_stall;
   logic              misalign_exc;
   logic              bus_err;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .Clk              (clk),
      .Clr              (clr),
      .MEM_MemRead      (mem_read),
      .MEM_MemWrite     (mem_write),
      .MEM_MemSize      (mem_size),
      .MEM_LoadUnsigned (load_unsigned),
      .MEM_ALUResult    (alu_result),
      .MEM_WriteData    (write_data),
      .DM_Req           (dm_req),
      .DM_We            (dm_we),
      .DM_Addr          (dm_addr),
      .DM_WData         (dm_wdata),
      .DM_BE            (dm_be),
      .DM_Ack           (dm_ack),
      .DM_RData         (dm_rdata),
      .MEM_ReadData     (read_data),
      .MemStall         (mem_stall),
      .MisalignExc      (misalign_exc),
      .BusErr           (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                              input logic [31:0] addr, input logic [31:0] rdata);
      logic [31:0] v;
      case (sz)
         2'b01: begin
            v = (rdata >> (addr[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
         end
         2'b10: begin
            v = (rdata >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
         end
         default: v = rdata;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
      case (sz)
         2'b01:   return addr[1] ? 4'b1100 : 4'b0011;
         2'b10:   return 4'(1 << int'(addr[1:0]));
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'b01:   return {wd[15:0], wd[15:0]};
         2'b10:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
         default: return wd;
      endcase
   endfunction

   task automatic idle_inputs();
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_size      = 2'b00;
      load_unsigned = 1'b0;
      alu_result    = 32'h0;
      write_data    = 32'h0;
   endtask

   // Called at posedge+1 with the unit in IDLE; returns at posedge+1 in IDLE.
   task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int ack_n);
      exp_t e;
      exp_t got_e;
      int   stall_cnt;
      e.we    = wr;
      e.rd    = wr ? 32'h0 : model_load(sz, uns, addr, rdata);
      e.addr  = (addr >> 2) & ((32'h1 << ADDR_W) - 1);
      e.be    = model_be(sz, addr);
      e.wdata = model_wdata(sz, wd);
      exp_q.push_back(e);

      mem_read = rd; mem_write = wr; mem_size = sz; load_unsigned = uns;
      alu_result = addr; write_data = wd;
      @(negedge clk);
      chk("stall_issue", mem_stall, 1);
      chk("req_before_issue", dm_req, 0);
      stall_cnt = mem_stall ? 1 : 0;
      @(posedge clk); #1;
      for (int k = 1; k <= ack_n; k++) begin
         if (k == ack_n) begin dm_ack = 1'b1; dm_rdata = rdata; end
         else dm_rdata = ~rdata;
         @(negedge clk);
         if (mem_stall) stall_cnt++;
         chk("req_wait", dm_req, 1);
         chk("addr", dm_addr, e.addr);
         chk("we", dm_we, e.we);
         if (wr) begin
            chk("be", dm_be, e.be);
            chk("wdata", dm_wdata, e.wdata);
         end
         @(posedge clk); #1;
      end
      dm_ack = 1'b0;
      dm_rdata = $urandom;
      @(negedge clk);
      got_e = exp_q.pop_front();
      chk("read_data", read_data, got_e.rd);
      chk("stall_cycles", stall_cnt, ack_n + 1);
      chk("done_stall", mem_stall, 0);
      chk("done_req", dm_req, 0);
      chk("done_buserr", bus_err, 0);
      $display("txn rd=%0b wr=%0b sz=%0d uns=%0b addr=0x%08h ack_n=%0d data=0x%08h",
               rd, wr, sz, uns, addr, ack_n, read_data);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("idle_data", read_data, 0);
      chk("idle_stall", mem_stall, 0);
      @(posedge clk); #1;
   endtask

   task automatic misalign_case(input logic [1:0] sz, input logic [31:0] addr);
      mem_read = 1'b1; mem_size = sz; alu_result = addr;
      @(negedge clk);
      chk("misalign_exc", misalign_exc, 1);
      chk("misalign_stall", mem_stall, 0);
      chk("misalign_req", dm_req, 0);
      chk("misalign_data", read_data, 0);
      $display("txn misaligned sz=%0d addr=0x%08h exc=%0b", sz, addr, misalign_exc);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("misalign_pulse_end", misalign_exc, 0);
      chk("misalign_req_after", dm_req, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      clr = 1'b1;
      dm_ack = 1'b0;
      dm_rdata = 32'h0;
      idle_inputs();
      mem_read = 1'b1;
      @(negedge clk);
      chk("rst_req", dm_req, 0);
      chk("rst_we", dm_we, 0);
      chk("rst_be", dm_be, 0);
      chk("rst_addr", dm_addr, 0);
      chk("rst_wdata", dm_wdata, 0);
      chk("rst_data", read_data, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_misalign", misalign_exc, 0);
      chk("rst_buserr", bus_err, 0);
      idle_inputs();
      @(posedge clk); #1;
      clr = 1'b0;
      @(posedge clk); #1;

      run_access(1, 0, 2'b00, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2);
      run_access(1, 0, 2'b10, 0, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1);
      run_access(1, 0, 2'b10, 1, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1);
      run_access(0, 1, 2'b01, 0, 32'h0000_0022, 32'h1234_ABCD, 32'h5555_5555, 3);
      run_access(1, 0, 2'b01, 0, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1);
      run_access(1, 0, 2'b01, 1, 32'h0000_0004, 32'h0, 32'h8001_FF7F, 2);
      run_access(0, 1, 2'b00, 0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1);
      run_access(0, 1, 2'b10, 0, 32'h0000_0001, 32'h0000_00A5, 32'h0, 2);
      run_access(1, 0, 2'b11, 1, 32'h0000_3FF8, 32'h0, 32'h0BAD_CAFE, 1);
      run_access(1, 1, 2'b00, 0, 32'h0000_0080, 32'h1111_2222, 32'hFFFF_FFFF, 1);

      misalign_case(2'b00, 32'h0000_0006);
      misalign_case(2'b01, 32'h0000_0005);

      // Stray ack while idle must not start anything.
      dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("stray_idle_stall", mem_stall, 0);
      @(posedge clk); #1;
      dm_ack = 1'b0;
      @(negedge clk);
      chk("stray_idle_req", dm_req, 0);
      chk("stray_idle_data", read_data, 0);
      @(posedge clk); #1;

      // Reset in the middle of WAIT, followed by a late ack.
      mem_read = 1'b1; mem_size = 2'b00; alu_result = 32'h0000_0100;
      @(posedge clk); #1;
      @(negedge clk);
      chk("clr_pre_req", dm_req, 1);
      #1;
      clr = 1'b1;
      idle_inputs();
      #1;
      chk("clr_req_drop", dm_req, 0);
      chk("clr_stall", mem_stall, 0);
      chk("clr_data", read_data, 0);
      @(posedge clk); #1;
      clr = 1'b0;
      dm_ack = 1'b1; dm_rdata = 32'hFEED_FACE;
      @(negedge clk);
      chk("clr_ack_req", dm_req, 0);
      chk("clr_ack_stall", mem_stall, 0);
      @(posedge clk); #1;
      dm_ack = 1'b0;
      @(negedge clk);
      chk("clr_ack_data", read_data, 0);
      chk("clr_ack_req2", dm_req, 0);
      $display("txn reset during WAIT, stray ack ignored");
      @(posedge clk); #1;

      run_access(1, 0, 2'b10, 0, 32'h0000_0202, 32'h0, 32'h0012_3456, 1);

`ifdef MEM_TIMEOUT_EN
      begin
         exp_t e;
         exp_t got_e;
         int   wc;
         bit   seen;
         e.rd = 32'h0; e.addr = 32'h40; e.be = 4'hF; e.wdata = 32'h0; e.we = 1'b0;
         exp_q.push_back(e);
         wc = 0; seen = 1'b0;
         mem_read = 1'b1; mem_size = 2'b00; alu_result = 32'h0000_0100;
         @(posedge clk); #1;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_err) seen = 1'b1;
            else if (dm_req && mem_stall) wc++;
            if (!seen) begin @(posedge clk); #1; end
         end
         got_e = exp_q.pop_front();
         chk("timeout_seen", seen, 1);
         chk("timeout_wait_cycles", wc, 4);
         chk("timeout_req", dm_req, 0);
         chk("timeout_stall", mem_stall, 0);
         chk("timeout_data", read_data, got_e.rd);
         $display("txn timeout wait_cycles=%0d buserr=%0b", wc, seen);
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         chk("timeout_pulse_end", bus_err, 0);
         @(posedge clk); #1;
      end
`endif

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
